// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - sequences a 4:1 mux select over enabled channels and packs sampled bits into a frame
module mux_scan_ctrl #(
  parameter int SETTLE = 2,
  parameter int CW     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic [3:0] en_mask,
  input  logic       f,
  output logic [1:0] sin,
  output logic [3:0] frame,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sin_q, sin_d;
  logic [3:0]    shadow_q, shadow_d;
  logic [3:0]    mask_q, mask_d;
  logic [3:0]    frame_q, frame_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic [3:0]    shadow_cap;
  logic          has_next;
  logic [1:0]    next_sel;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    lowest = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) lowest = 2'(i);
  endfunction

  always_comb begin
    has_next = 1'b0;
    next_sel = sin_q;
    for (int i = 0; i < 4; i++) begin
      if (!has_next && mask_q[i] && (i > int'(sin_q))) begin
        has_next = 1'b1;
        next_sel = 2'(i);
      end
    end
    shadow_cap        = shadow_q;
    shadow_cap[sin_q] = f;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sin_d    = sin_q;
    shadow_d = shadow_q;
    mask_d   = mask_q;
    frame_d  = frame_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start && (en_mask != 4'b0000)) begin
          mask_d   = en_mask;
          shadow_d = 4'b0000;
          sin_d    = lowest(en_mask);
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == LAST) begin
          shadow_d = shadow_cap;
          if (has_next) begin
            sin_d = next_sel;
            cnt_d = '0;
          end else begin
            frame_d = shadow_cap;
            valid_d = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (ready) begin
          valid_d = 1'b0;
          // rescan decision uses the live mask at the moment of transfer
          if (cont && (en_mask != 4'b0000)) begin
            mask_d   = en_mask;
            shadow_d = 4'b0000;
            sin_d    = lowest(en_mask);
            cnt_d    = '0;
            state_d  = S_SETTLE;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sin_q    <= 2'b00;
      shadow_q <= 4'b0000;
      mask_q   <= 4'b0000;
      frame_q  <= 4'b0000;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sin_q    <= sin_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign sin   = sin_q;
  assign frame = frame_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - scoreboard bench for mux_scan_ctrl with a behavioural 4:1 mux in the loop
module tb_mux_scan_ctrl;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic [3:0] en_mask = 4'b0000;
  logic [3:0] mux_in = 4'b0000;
  logic       f;
  logic [1:0] sin;
  logic [3:0] frame;
  logic       valid;
  logic       ready = 1'b0;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] frame;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  // behavioural mux: f = {d,c,b,a}[sin]
  assign f = mux_in[sin];

  mux_scan_ctrl #(.SETTLE(S), .CW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .en_mask(en_mask),
    .f(f), .sin(sin), .frame(frame), .valid(valid), .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int popc(input logic [3:0] m);
    popc = 0;
    for (int i = 0; i < 4; i++) popc += int'(m[i]);
  endfunction

  function automatic logic [1:0] highest(input logic [3:0] m);
    highest = 2'd0;
    for (int i = 0; i < 4; i++) if (m[i]) highest = 2'(i);
  endfunction

  // monitor: compare every rising valid against the scoreboard head
  logic valid_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      valid_prev = 1'b0;
    end else begin
      if (valid && !valid_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("frame", {28'd0, frame}, {28'd0, e.frame});
          chk("valid_latency", cyc, e.cyc);
        end
      end
      valid_prev = valid;
    end
  end

  logic [1:0] last_sin = 2'b00;
  logic [3:0] last_frame = 4'b0000;

  task automatic push_exp(input logic [3:0] mask, input logic [3:0] data);
    exp_t e;
    e.frame = data & mask;
    e.cyc   = cyc + 1 + popc(mask) * S;
    exp_q.push_back(e);
  endtask

  task automatic launch(input logic [3:0] mask, input logic [3:0] data, input logic cm);
    mux_in  = data;
    en_mask = mask;
    cont    = cm;
    start   = 1'b1;
    push_exp(mask, data);
    @(negedge clk);
    start = 1'b0;
  endtask

  // walk the select sequence: ascending enabled channels, S cycles each
  task automatic body(input logic [3:0] mask, input bit mid_start);
    int n;
    n = 0;
    for (int ch = 0; ch < 4; ch++) begin
      if (mask[ch]) begin
        for (int k = 0; k < S; k++) begin
          chk("scan_sin", {30'd0, sin}, ch);
          chk("scan_valid", {31'd0, valid}, 32'd0);
          chk("scan_busy", {31'd0, busy}, 32'd1);
          start = (mid_start && n == 1) ? 1'b1 : 1'b0;
          en_mask = 4'($urandom);
          n++;
          @(negedge clk);
        end
      end
    end
    start = 1'b0;
    chk("done_valid", {31'd0, valid}, 32'd1);
    chk("done_sin", {30'd0, sin}, {30'd0, highest(mask)});
  endtask

  task automatic deliver(input logic [3:0] mask, input logic [3:0] data, input int hold,
                         input logic cm, input logic [3:0] nmask, input logic [3:0] ndata,
                         output bit again);
    for (int h = 0; h < hold; h++) begin
      ready  = 1'b0;
      mux_in = 4'($urandom);
      @(negedge clk);
      chk("hold_valid", {31'd0, valid}, 32'd1);
      chk("hold_frame", {28'd0, frame}, {28'd0, data & mask});
      chk("hold_sin", {30'd0, sin}, {30'd0, highest(mask)});
    end
    ready   = 1'b1;
    cont    = cm;
    en_mask = nmask;
    mux_in  = ndata;
    again   = cm && (nmask != 4'b0000);
    if (again) push_exp(nmask, ndata);
    @(negedge clk);
    ready = 1'b0;
    chk("xfer_valid", {31'd0, valid}, 32'd0);
    chk("xfer_busy", {31'd0, busy}, {31'd0, again});
    chk("xfer_frame_kept", {28'd0, frame}, {28'd0, data & mask});
    last_sin   = highest(mask);
    last_frame = data & mask;
  endtask

  initial begin
    bit         again;
    logic [3:0] m, d, nm, nd;
    logic       cm;

    #2;
    chk("rst_sin", {30'd0, sin}, 32'd0);
    chk("rst_frame", {28'd0, frame}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // a=1 b=0 c=1 d=1, all channels
    launch(4'b1111, 4'b1101, 1'b0);
    body(4'b1111, 1'b0);
    deliver(4'b1111, 4'b1101, 0, 1'b0, 4'b1111, 4'b1101, again);

    // sparse mask, only b and d visited
    launch(4'b1010, 4'b0111, 1'b0);
    body(4'b1010, 1'b0);
    deliver(4'b1010, 4'b0111, 0, 1'b0, 4'b1010, 4'b0111, again);

    // backpressure with mux inputs toggling
    launch(4'b0110, 4'b0110, 1'b0);
    body(4'b0110, 1'b0);
    deliver(4'b0110, 4'b0110, 5, 1'b0, 4'b0110, 4'b0000, again);

    // continuous single-channel frames, a toggling
    d = 4'b0001;
    launch(4'b0001, d, 1'b1);
    for (int i = 0; i < 4; i++) begin
      body(4'b0001, 1'b0);
      deliver(4'b0001, d, 0, 1'b1, 4'b0001, d ^ 4'b0001, again);
      d = d ^ 4'b0001;
    end
    body(4'b0001, 1'b0);
    deliver(4'b0001, d, 0, 1'b0, 4'b0001, d, again);

    // start with empty mask is ignored
    en_mask = 4'b0000;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("nomask_valid", {31'd0, valid}, 32'd0);
      chk("nomask_busy", {31'd0, busy}, 32'd0);
      chk("nomask_sin", {30'd0, sin}, {30'd0, last_sin});
      chk("nomask_frame", {28'd0, frame}, {28'd0, last_frame});
      @(negedge clk);
    end

    // start mid-scan is ignored
    launch(4'b1011, 4'b1001, 1'b0);
    body(4'b1011, 1'b1);
    deliver(4'b1011, 4'b1001, 1, 1'b0, 4'b0000, 4'b0000, again);

    // reset during channel 2 settle
    launch(4'b1111, 4'b1111, 1'b0);
    repeat (2 * S) @(negedge clk);
    chk("pre_rst_sin", {30'd0, sin}, 32'd2);
    rst = 1'b1;
    #1;
    chk("async_rst_sin", {30'd0, sin}, 32'd0);
    chk("async_rst_frame", {28'd0, frame}, 32'd0);
    chk("async_rst_valid", {31'd0, valid}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    last_sin = 2'b00;
    launch(4'b0101, 4'b1111, 1'b0);
    body(4'b0101, 1'b0);
    deliver(4'b0101, 4'b1111, 0, 1'b0, 4'b0000, 4'b0000, again);

    // randomized scans with random backpressure and rescans
    again = 1'b0;
    m = 4'b0001;
    d = 4'b0000;
    for (int i = 0; i < 30; i++) begin
      if (!again) begin
        m = 4'($urandom_range(1, 15));
        d = 4'($urandom);
        launch(m, d, 1'($urandom));
      end
      body(m, 1'($urandom));
      nm = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      nd = 4'($urandom);
      cm = 1'($urandom);
      deliver(m, d, $urandom_range(0, 3), cm, nm, nd, again);
      if (again) begin
        m = nm;
        d = nd;
      end
    end
    if (again) begin
      body(m, 1'b0);
      deliver(m, d, 0, 1'b0, 4'b0000, 4'b0000, again);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
